// File: rtl/seq_hit_logger_if.sv
// seq_hit_logger bus: detector sample inputs,
// pop handshake and logger status outputs.
interface seq_hit_logger_if #(
  parameter int TS_W  = 8,
  parameter int CNT_W = 8
);

  logic             en;
  logic             hit;
  logic             rd_en;
  logic [TS_W-1:0]  rd_data;
  logic             empty;
  logic             full;
  logic             overflow;
  logic [CNT_W-1:0] hit_cnt;
  logic [TS_W-1:0]  ts;

  modport master (
    output en,
    output hit,
    output rd_en,
    input  rd_data,
    input  empty,
    input  full,
    input  overflow,
    input  hit_cnt,
    input  ts
  );

  modport slave (
    input  en,
    input  hit,
    input  rd_en,
    output rd_data,
    output empty,
    output full,
    output overflow,
    output hit_cnt,
    output ts
  );

endinterface

// File: rtl/seq_hit_logger.sv
// seq_hit_logger: timestamps each sampled detector
// match into a small FWFT FIFO with sticky overflow.
module seq_hit_logger #(
  parameter int TS_W  = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rstn,
  seq_hit_logger_if.slave    bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic push;
  logic pop;
  logic wr_ok;
  logic drop;
  logic is_empty;
  logic is_full;
  logic cnt_sat;

  assign is_empty = (occ == '0);
  assign is_full  = (occ == OCC_FULL);
  assign push     = bus.en & bus.hit;
  assign pop      = bus.rd_en & ~is_empty;
  // a full FIFO still accepts when the head
  // leaves on the same edge
  assign wr_ok    = push & (~is_full | pop);
  assign drop     = push & is_full & ~pop;
  assign cnt_sat  = (cnt_q == '1);

  // free-running timestamp, advances with en
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ts_q <= '0;
    end else if (bus.en) begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  // storage; pointers gate visibility so no reset
  always_ff @(posedge clk) begin
    if (rstn && wr_ok) begin
      mem[wr_ptr] <= ts_q;
    end
  end

  // write/read pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (1'b1)
        (wr_ok && !pop): occ <= occ + (AW+1)'(1);
        (pop && !wr_ok): occ <= occ - (AW+1)'(1);
        default:         occ <= occ;
      endcase
    end
  end

  // sticky drop flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  // saturating count of every sampled hit
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (push && !cnt_sat) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.rd_data  = is_empty ? '0 : mem[rd_ptr];
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.overflow = ovf_q;
  assign bus.hit_cnt  = cnt_q;
  assign bus.ts       = ts_q;

endmodule

// File: tb/tb_seq_hit_logger.sv
// tb_seq_hit_logger: queue-based reference model,
// per-cycle compare, directed and random stimulus.
module tb_seq_hit_logger;

  localparam int TS_W  = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int TS_M  = 1 << TS_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  seq_hit_logger_if #(.TS_W(TS_W), .CNT_W(CNT_W)) bus ();

  seq_hit_logger #(
    .TS_W(TS_W),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  int q[$];
  int m_ts = 0;
  bit m_ovf = 1'b0;
  int m_cnt = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d",
               nm, $time, act, exp);
    end
  endtask

  // reference model: FIFO as a queue of timestamps
  always @(posedge clk) begin
    bit push;
    bit pop;
    if (!rstn) begin
      q.delete();
      m_ts = 0;
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      push = bus.en && bus.hit;
      pop = bus.rd_en && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(m_ts);
        else m_ovf = 1'b1;
        if (m_cnt < CMAX) m_cnt++;
      end
      if (bus.en) m_ts = (m_ts + 1) % TS_M;
    end
  end

  // every-cycle compare against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rd_data", bus.rd_data,
          q.size() > 0 ? q[0] : 0);
      chk("empty", bus.empty, q.size() == 0);
      chk("full", bus.full, q.size() == DEPTH);
      chk("overflow", bus.overflow, m_ovf);
      chk("hit_cnt", bus.hit_cnt, m_cnt);
      chk("ts", bus.ts, m_ts);
    end
  end

  task automatic step(input logic e,
                      input logic h,
                      input logic r,
                      input logic rs = 1'b1);
    bus.en = e;
    bus.hit = h;
    bus.rd_en = r;
    rstn = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop_chk(input string nm,
                         input int exp);
    chk(nm, bus.rd_data, exp);
    step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int t0;
    bus.en = 1'b0;
    bus.hit = 1'b0;
    bus.rd_en = 1'b0;

    // reset with en/hit high
    do_reset();
    chk_on = 1'b1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_cnt", bus.hit_cnt, 0);
    chk("rst_ts", bus.ts, 0);
    chk("rst_rd", bus.rd_data, 0);

    // basic log: hits at ts 3 and 6
    for (int i = 0; i < 8; i++)
      step(1'b1, (i == 3) || (i == 6), 1'b0);
    pop_chk("basic_1", 3);
    pop_chk("basic_2", 6);
    chk("basic_empty", bus.empty, 1);
    chk("basic_rd0", bus.rd_data, 0);
    chk("basic_cnt", bus.hit_cnt, 2);

    // overflow: hits at ts 1..5
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == 4) chk("ovf_full", bus.full, 1);
      if (i == 4) chk("ovf_pre", bus.overflow, 0);
    end
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_cnt", bus.hit_cnt, 5);
    for (int i = 1; i <= 4; i++)
      pop_chk("ovf_rd", i);
    chk("ovf_empty", bus.empty, 1);
    chk("ovf_sticky", bus.overflow, 1);

    // full with simultaneous push+pop
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++)
      step(1'b1, i <= 4, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("pp_ovf", bus.overflow, 0);
    chk("pp_full", bus.full, 1);
    pop_chk("pp_rd", 2);
    pop_chk("pp_rd", 3);
    pop_chk("pp_rd", 4);
    pop_chk("pp_rd", 9);
    chk("pp_empty", bus.empty, 1);

    // enable gating
    t0 = bus.ts;
    repeat (5) step(1'b0, 1'b1, 1'b0);
    chk("gate_ts", bus.ts, t0);
    chk("gate_empty", bus.empty, 1);
    chk("gate_cnt", bus.hit_cnt, 5);

    // timestamp wrap: hits at 255 and 0
    while (m_ts != 254) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    pop_chk("wrap_rd", 255);
    pop_chk("wrap_rd", 0);

    // reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("mid_cnt", bus.hit_cnt, 7);
    chk("mid_ovf", bus.overflow, 1);
    chk("mid_empty", bus.empty, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("mid_rst_empty", bus.empty, 1);
    chk("mid_rst_ovf", bus.overflow, 0);
    chk("mid_rst_cnt", bus.hit_cnt, 0);
    chk("mid_rst_ts", bus.ts, 0);
    step(1'b0, 1'b0, 1'b1);
    chk("mid_pop_empty", bus.empty, 1);
    chk("mid_pop_rd", bus.rd_data, 0);
    chk("mid_pop_full", bus.full, 0);

    // hit counter saturation
    repeat (300) step(1'b1, 1'b1, 1'b1);
    chk("sat_cnt", bus.hit_cnt, 255);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3, 0) != 0,
           $urandom_range(1, 0) == 1,
           $urandom_range(2, 0) == 0,
           $urandom_range(499, 0) != 0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_hit_logger.md
# seq_hit_logger

Downstream consumer of the serial sequence detector: samples the detector's one-bit match output every advancing cycle and records a timestamp for each match in a small first-word-fall-through FIFO. A host or bench reads the timestamps with a single-signal pop handshake. The block also keeps a saturating total match count and a sticky overflow flag, so no detection is silently lost.

## Interface
- TS_W, 8, timestamp width; free-running cycle counter wraps at 2^TS_W
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 8, width of total match counter
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- en  in  1  advance strobe; timestamp counter and hit sampling act only when en=1 (same enable that shifts the detector's input)
- hit  in  1  detector match output; each sampled cycle with hit=1 is one event (no edge detection; overlapping matches count separately)
- rd_en  in  1  pop request for FIFO head
- rd_data  out  TS_W  head timestamp; 0 when empty
- empty  out  1  FIFO holds no entries
- full  out  1  FIFO holds DEPTH entries
- overflow  out  1  sticky: a hit was dropped because FIFO was full
- hit_cnt  out  CNT_W  total sampled hits incl. dropped, saturates at 2^CNT_W−1
- ts  out  TS_W  current timestamp counter value

## Operation
- Reset (rstn=0 at edge): ts=0, FIFO emptied (wr/rd pointers 0, occupancy 0), empty=1, full=0, overflow=0, hit_cnt=0, rd_data=0. Inputs in that cycle ignored.
- Timestamp: on edge with en=1, ts ← ts+1 mod 2^TS_W; en=0 holds ts.
- push = en & hit. Value written is ts before its increment in the same edge.
- pop = rd_en & ~empty. rd_en while empty ignored; no error flag.
- Occupancy rules per edge:
  - push only, not full: write at wr_ptr, wr_ptr+1, occupancy+1.
  - push only, full: entry dropped, overflow←1, pointers unchanged.
  - pop only: rd_ptr+1, occupancy−1.
  - push and pop, any occupancy ≥1: both performed, occupancy unchanged, no overflow (full stays full).
  - push and pop while empty: pop ignored, push performed.
- Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits to distinguish full from empty.
- hit_cnt increments on every push (accepted or dropped) until saturated, then holds.
- overflow clears only on reset.
- rd_data = mem[rd_ptr] when ~empty else 0 (combinational from registered state).

## Timing
- Push at edge k: empty deasserts and rd_data shows entry after edge k (zero-cycle fall-through when FIFO was empty).
- Pop at edge k: rd_data shows next entry (or 0, empty=1) after edge k.
- full/empty/overflow/hit_cnt are registered-state functions; update after the edge causing the change.
- No combinational path from hit or en to any output; rd_en affects outputs only via the edge.
- Reset mid-operation: single low cycle clears all state regardless of contents; first en=1 cycle after release samples ts=0.

## Test plan
- Reset: hold rstn=0 one edge with hit=en=1 -> empty=1, full=0, overflow=0, hit_cnt=0, ts=0, rd_data=0.
- Basic log: en=1 continuous from ts=0, hit=1 only when ts=3 and ts=6, then rd_en one cycle twice -> rd_data=3, then 6, then empty=1, rd_data=0; hit_cnt=2.
- Overflow (DEPTH=4): hits at ts=1..5, no reads -> full=1 after 4th, 5th dropped, overflow=1, hit_cnt=5; reads return 1,2,3,4 then empty; overflow stays 1.
- Full with simultaneous push+pop: FIFO holds 1,2,3,4, hit at ts=9 with rd_en=1 -> overflow=0, full=1, contents 2,3,4,9.
- Enable gating and wrap: en=0 with hit=1 for 5 cycles -> ts frozen, no push; run en=1 from ts=254 with hit at ts=255 and next cycle -> entries 255 then 0.
- Reset mid-operation: 2 entries queued, overflow=1, hit_cnt=7, drive rstn=0 one edge -> all outputs return to reset values; pop on empty afterwards ignored.
